uart_tx_prescaled: RTL

//   UART transmitter driven from the oversampling (RX-rate) clock, the transmit-side counterpart
//   of UART_RX. Serialises one DATA_WIDTH word per handshake into start/data/parity/stop frames.
//   Bit period = Prescale clock cycles, using the same PAR_EN/PAR_TYP/Prescale fields as the

---
 rtl/uart_tx_prescaled_pkg.sv | 20 ++
 rtl/uart_tx_prescaled_if.sv | 36 +++
 rtl/uart_tx_prescaled_bit_timer.sv | 35 +++
 rtl/uart_tx_prescaled.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_prescaled_pkg.sv
// Shared UART definitions: transmitter FSM states, minimum prescale and the parity rule.
// Both ends of the link use the same parity_bit so their parity definitions cannot drift apart.
package uart_tx_prescaled_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    localparam int unsigned MIN_PRESCALE = 4;

    // Words are zero-extended to 32 bits; extra zeros leave the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [31:0] data, input logic typ);
        return typ ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_prescaled_if.sv
// Request/config and serial-line signals between a word source and the prescaled UART transmitter.
// The master drives words and config; the slave (the transmitter) drives the line and Busy.
interface uart_tx_prescaled_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);

    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        output P_DATA,
        output DATA_VALID,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        input  P_DATA,
        input  DATA_VALID,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_prescaled_bit_timer.sv
// Bit-period counter: runs 0..prescale-1 while enabled and pulses bit_done_o on the last cycle.
// The counter wraps to zero on each bit boundary so consecutive bits share one timebase.
module uart_tx_prescaled_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      bit_done_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

    assign bit_done_o = en_i && (cnt_q == (prescale_i - PRESCALE_WIDTH'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || bit_done_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_prescaled.sv
// UART transmitter clocked from the oversampling clock: one bit lasts Prescale cycles.
// Config and word are shadowed at accept so a frame is immune to input changes while Busy.
module uart_tx_prescaled
    import uart_tx_prescaled_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_prescaled_if.slave tx_if
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] MinPrescale = PRESCALE_WIDTH'(MIN_PRESCALE);

    tx_state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic timer_en;
    logic timer_clear;
    logic bit_done;

    assign timer_en = (state_q != StIdle);

    uart_tx_prescaled_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .en_i      (timer_en),
        .clear_i   (timer_clear),
        .prescale_i(presc_q),
        .bit_done_o(bit_done)
    );

    // Outputs are computed for the next state so TX_OUT/Busy stay pure flop outputs.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        presc_d     = presc_q;
        idx_d       = idx_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        timer_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_if.DATA_VALID) begin
                    data_d      = tx_if.P_DATA;
                    shift_d     = tx_if.P_DATA;
                    par_en_d    = tx_if.PAR_EN;
                    par_typ_d   = tx_if.PAR_TYP;
                    presc_d     = (tx_if.Prescale < MinPrescale) ? MinPrescale : tx_if.Prescale;
                    idx_d       = '0;
                    timer_clear = 1'b1;
                    state_d     = StStart;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    shift_d = data_q;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end

            StData: begin
                if (bit_done) begin
                    if (idx_q == LastIdx) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = parity_bit(32'(data_q), par_typ_q);
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end

            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end

            StStop: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= MinPrescale;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.Busy   = busy_q;

endmodule
